param_iqueue: RTL and testbench

PARAM_IQUEUE -- requirements
Module: param_iqueue

---
 rtl/param_iqueue_pkg.sv | 85 ++++++++
 rtl/param_iqueue_decode.sv | 131 +++++++++++++
 rtl/param_iqueue.sv | 175 +++++++++++++++++
 tb/tb_param_iqueue.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_iqueue_pkg.sv
// Shared constants for the instruction queue: default sizing, major opcodes,
// instruction-class encodings and opcode ids reported on issue.
package param_iqueue_pkg;

  localparam int QUE_DEPTH     = 16;
  localparam int QUE_AF_MARGIN = 2;
  localparam int QUE_XLEN      = 32;

  typedef enum logic [1:0] {
    TYPE_ALU = 2'd0,
    TYPE_MEM = 2'd1,
    TYPE_BR  = 2'd2,
    TYPE_VEC = 2'd3
  } itype_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_V   = 7'b1010111;

  localparam logic [5:0] NAME_ILLEGAL = 6'd0;
  localparam logic [5:0] NAME_ADD     = 6'd1;
  localparam logic [5:0] NAME_SUB     = 6'd2;
  localparam logic [5:0] NAME_SLL     = 6'd3;
  localparam logic [5:0] NAME_SLT     = 6'd4;
  localparam logic [5:0] NAME_SLTU    = 6'd5;
  localparam logic [5:0] NAME_XOR     = 6'd6;
  localparam logic [5:0] NAME_SRL     = 6'd7;
  localparam logic [5:0] NAME_SRA     = 6'd8;
  localparam logic [5:0] NAME_OR      = 6'd9;
  localparam logic [5:0] NAME_AND     = 6'd10;
  localparam logic [5:0] NAME_ADDI    = 6'd11;
  localparam logic [5:0] NAME_SLTI    = 6'd12;
  localparam logic [5:0] NAME_SLTIU   = 6'd13;
  localparam logic [5:0] NAME_XORI    = 6'd14;
  localparam logic [5:0] NAME_ORI     = 6'd15;
  localparam logic [5:0] NAME_ANDI    = 6'd16;
  localparam logic [5:0] NAME_SLLI    = 6'd17;
  localparam logic [5:0] NAME_SRLI    = 6'd18;
  localparam logic [5:0] NAME_SRAI    = 6'd19;
  localparam logic [5:0] NAME_LUI     = 6'd20;
  localparam logic [5:0] NAME_AUIPC   = 6'd21;
  localparam logic [5:0] NAME_JAL     = 6'd22;
  localparam logic [5:0] NAME_JALR    = 6'd23;
  localparam logic [5:0] NAME_BEQ     = 6'd24;
  localparam logic [5:0] NAME_BNE     = 6'd25;
  localparam logic [5:0] NAME_BLT     = 6'd26;
  localparam logic [5:0] NAME_BGE     = 6'd27;
  localparam logic [5:0] NAME_BLTU    = 6'd28;
  localparam logic [5:0] NAME_BGEU    = 6'd29;
  localparam logic [5:0] NAME_LB      = 6'd30;
  localparam logic [5:0] NAME_LH      = 6'd31;
  localparam logic [5:0] NAME_LW      = 6'd32;
  localparam logic [5:0] NAME_LBU     = 6'd33;
  localparam logic [5:0] NAME_LHU     = 6'd34;
  localparam logic [5:0] NAME_SB      = 6'd35;
  localparam logic [5:0] NAME_SH      = 6'd36;
  localparam logic [5:0] NAME_SW      = 6'd37;
  localparam logic [5:0] NAME_VADD    = 6'd38;
  localparam logic [5:0] NAME_VSUB    = 6'd39;

  // Register and immediate ALU forms share funct3; alt is instruction bit 30.
  function automatic logic [5:0] alu_name(input logic [2:0] f3, input logic alt,
                                          input logic imm_form);
    logic [5:0] n;
    case (f3)
      3'd0:    n = imm_form ? NAME_ADDI : (alt ? NAME_SUB : NAME_ADD);
      3'd1:    n = imm_form ? NAME_SLLI : NAME_SLL;
      3'd2:    n = imm_form ? NAME_SLTI : NAME_SLT;
      3'd3:    n = imm_form ? NAME_SLTIU : NAME_SLTU;
      3'd4:    n = imm_form ? NAME_XORI : NAME_XOR;
      3'd5:    n = imm_form ? (alt ? NAME_SRAI : NAME_SRLI) : (alt ? NAME_SRA : NAME_SRL);
      3'd6:    n = imm_form ? NAME_ORI : NAME_OR;
      default: n = imm_form ? NAME_ANDI : NAME_AND;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/param_iqueue_decode.sv
// Purely combinational decode of the queue head: operand sources, class,
// opcode id and the sign-extended immediate for the instruction format.
module param_iqueue_decode
  import param_iqueue_pkg::*;
#(
  parameter int XLEN = QUE_XLEN
) (
  input  logic [31:0]     inst_i,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [1:0]      itype_o,
  output logic [5:0]      name_o,
  output logic            is_vec_o,
  output logic            is_imm_o,
  output logic            is_pc_o,
  output logic [XLEN-1:0] imm_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [5:0]      funct6;
  logic            alt;
  logic [XLEN-1:0] imm_i_fmt;
  logic [XLEN-1:0] imm_s_fmt;
  logic [XLEN-1:0] imm_b_fmt;
  logic [XLEN-1:0] imm_u_fmt;
  logic [XLEN-1:0] imm_j_fmt;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct6 = inst_i[31:26];
  assign alt    = inst_i[30];
  assign rs1_o  = inst_i[19:15];
  assign rs2_o  = inst_i[24:20];

  assign imm_i_fmt = {{(XLEN-11){inst_i[31]}}, inst_i[30:20]};
  assign imm_s_fmt = {{(XLEN-11){inst_i[31]}}, inst_i[30:25], inst_i[11:7]};
  assign imm_b_fmt = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u_fmt = {{(XLEN-31){inst_i[31]}}, inst_i[30:12], 12'b0};
  assign imm_j_fmt = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  always_comb begin
    rd_o     = inst_i[11:7];
    itype_o  = TYPE_ALU;
    name_o   = NAME_ILLEGAL;
    is_vec_o = 1'b0;
    is_imm_o = 1'b0;
    is_pc_o  = 1'b0;
    imm_o    = '0;
    case (opcode)
      OPC_OP: name_o = alu_name(funct3, alt, 1'b0);
      OPC_OP_IMM: begin
        name_o   = alu_name(funct3, alt, 1'b1);
        is_imm_o = 1'b1;
        imm_o    = imm_i_fmt;
      end
      // Upper-immediate and JAL forms take the PC as operand 1, so they
      // never wait on the register file.
      OPC_LUI, OPC_AUIPC: begin
        name_o   = (opcode == OPC_LUI) ? NAME_LUI : NAME_AUIPC;
        is_imm_o = 1'b1;
        is_pc_o  = 1'b1;
        imm_o    = imm_u_fmt;
      end
      OPC_JAL: begin
        itype_o  = TYPE_BR;
        name_o   = NAME_JAL;
        is_imm_o = 1'b1;
        is_pc_o  = 1'b1;
        imm_o    = imm_j_fmt;
      end
      OPC_JALR: begin
        itype_o  = TYPE_BR;
        name_o   = NAME_JALR;
        is_imm_o = 1'b1;
        imm_o    = imm_i_fmt;
      end
      OPC_BRANCH: begin
        rd_o    = '0;
        itype_o = TYPE_BR;
        imm_o   = imm_b_fmt;
        case (funct3)
          3'd0:    name_o = NAME_BEQ;
          3'd1:    name_o = NAME_BNE;
          3'd4:    name_o = NAME_BLT;
          3'd5:    name_o = NAME_BGE;
          3'd6:    name_o = NAME_BLTU;
          3'd7:    name_o = NAME_BGEU;
          default: name_o = NAME_ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        itype_o  = TYPE_MEM;
        is_imm_o = 1'b1;
        imm_o    = imm_i_fmt;
        case (funct3)
          3'd0:    name_o = NAME_LB;
          3'd1:    name_o = NAME_LH;
          3'd2:    name_o = NAME_LW;
          3'd4:    name_o = NAME_LBU;
          3'd5:    name_o = NAME_LHU;
          default: name_o = NAME_ILLEGAL;
        endcase
      end
      // Stores need rs2 as write data, so the offset travels in imm only.
      OPC_STORE: begin
        rd_o    = '0;
        itype_o = TYPE_MEM;
        imm_o   = imm_s_fmt;
        case (funct3)
          3'd0:    name_o = NAME_SB;
          3'd1:    name_o = NAME_SH;
          3'd2:    name_o = NAME_SW;
          default: name_o = NAME_ILLEGAL;
        endcase
      end
      OPC_OP_V: begin
        itype_o  = TYPE_VEC;
        is_vec_o = 1'b1;
        case (funct6)
          6'b000000: name_o = NAME_VADD;
          6'b000010: name_o = NAME_VSUB;
          default:   name_o = NAME_ILLEGAL;
        endcase
      end
      default: rd_o = '0;
    endcase
  end

endmodule

// File: rtl/param_iqueue.sv
// In-order instruction queue between IFetch and issue: circular buffer with
// wrap-bit pointers, registered almost-full, and registered issue outputs.
module param_iqueue
  import param_iqueue_pkg::*;
#(
  parameter int DEPTH     = QUE_DEPTH,
  parameter int AF_MARGIN = QUE_AF_MARGIN,
  parameter int XLEN      = QUE_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            inst_rdy,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc_in,
  output logic            iqueue_full,
  input  logic            ins_rdy,
  input  logic            bubble,
  input  logic            op1_rdy,
  input  logic            op2_rdy,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            issue_rdy,
  output logic [4:0]      rd,
  output logic [1:0]      itype,
  output logic [5:0]      name,
  output logic            is_vec,
  output logic            is_imm,
  output logic            is_pc,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] imm
);

  localparam int            AW         = $clog2(DEPTH);
  localparam int            PW         = AW + 1;
  localparam logic [PW-1:0] FULL_COUNT = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LEVEL   = PW'(DEPTH - AF_MARGIN);

  // Asynchronous-read storage: the head entry must reach Decode and the
  // rs1/rs2 lookup in the same cycle it becomes the head.
  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]   count, next_count;
  logic            empty, full, enq_fire, issue_fire;
  logic [31:0]     head_inst;
  logic [XLEN-1:0] head_pc;

  logic [4:0]      dec_rd;
  logic [1:0]      dec_type;
  logic [5:0]      dec_name;
  logic            dec_vec, dec_imm_sel, dec_pc_sel;
  logic [XLEN-1:0] dec_imm;

  logic            issue_q, issue_d, full_q, full_d;
  logic [4:0]      rd_q, rd_d;
  logic [1:0]      type_q, type_d;
  logic [5:0]      name_q, name_d;
  logic            vec_q, vec_d, imm_sel_q, imm_sel_d, pc_sel_q, pc_sel_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;

  assign count     = tail_q - head_q;
  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign head_inst = inst_mem[head_q[AW-1:0]];
  assign head_pc   = pc_mem[head_q[AW-1:0]];

  param_iqueue_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .inst_i   (head_inst),
    .rs1_o    (rs1),
    .rs2_o    (rs2),
    .rd_o     (dec_rd),
    .itype_o  (dec_type),
    .name_o   (dec_name),
    .is_vec_o (dec_vec),
    .is_imm_o (dec_imm_sel),
    .is_pc_o  (dec_pc_sel),
    .imm_o    (dec_imm)
  );

  assign enq_fire   = inst_rdy && !full;
  assign issue_fire = ins_rdy && !bubble && !empty
                      && (dec_pc_sel || op1_rdy) && (dec_imm_sel || op2_rdy);

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    issue_d   = 1'b0;
    rd_d      = rd_q;
    type_d    = type_q;
    name_d    = name_q;
    vec_d     = vec_q;
    imm_sel_d = imm_sel_q;
    pc_sel_d  = pc_sel_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (issue_fire) begin
        head_d    = head_q + PW'(1);
        issue_d   = 1'b1;
        rd_d      = dec_rd;
        type_d    = dec_type;
        name_d    = dec_name;
        vec_d     = dec_vec;
        imm_sel_d = dec_imm_sel;
        pc_sel_d  = dec_pc_sel;
        pc_d      = head_pc;
        imm_d     = dec_imm;
      end
      if (enq_fire) begin
        tail_d = tail_q + PW'(1);
      end
    end
    // Almost-full looks at the post-edge occupancy so IFetch sees it one
    // cycle early enough to stop before the last free slot is consumed.
    next_count = tail_d - head_d;
    full_d     = !flush && (next_count >= AF_LEVEL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      issue_q   <= 1'b0;
      full_q    <= 1'b0;
      rd_q      <= '0;
      type_q    <= '0;
      name_q    <= '0;
      vec_q     <= 1'b0;
      imm_sel_q <= 1'b0;
      pc_sel_q  <= 1'b0;
      pc_q      <= '0;
      imm_q     <= '0;
    end else if (rdy) begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      issue_q   <= issue_d;
      full_q    <= full_d;
      rd_q      <= rd_d;
      type_q    <= type_d;
      name_q    <= name_d;
      vec_q     <= vec_d;
      imm_sel_q <= imm_sel_d;
      pc_sel_q  <= pc_sel_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush && enq_fire) begin
      inst_mem[tail_q[AW-1:0]] <= inst;
      pc_mem[tail_q[AW-1:0]]   <= pc_in;
    end
  end

  assign iqueue_full = full_q;
  assign issue_rdy   = issue_q;
  assign rd          = rd_q;
  assign itype       = type_q;
  assign name        = name_q;
  assign is_vec      = vec_q;
  assign is_imm      = imm_sel_q;
  assign is_pc       = pc_sel_q;
  assign pc_out      = pc_q;
  assign imm         = imm_q;

endmodule

// File: tb/tb_param_iqueue.sv
// Directed and randomized checks of param_iqueue against a queue-based model
// whose expected decode comes from how each instruction word was built.
module tb_param_iqueue;

  localparam int DEPTH = 16;
  localparam int AF    = 2;

  localparam int K_ADD = 0, K_SUB = 1, K_ADDI = 2, K_LUI = 3, K_AUIPC = 4;
  localparam int K_LW = 5, K_SW = 6, K_BEQ = 7, K_JAL = 8, K_VADD = 9;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use_rs1;
    logic        use_rs2;
    logic [1:0]  typ;
    logic [5:0]  nm;
    logic        vec;
    logic        isimm;
    logic        ispc;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, inst_rdy, ins_rdy, bubble, op1_rdy, op2_rdy;
  logic [31:0] inst, pc_in;
  logic        iqueue_full, issue_rdy, is_vec, is_imm, is_pc;
  logic [4:0]  rs1, rs2, rd;
  logic [1:0]  itype;
  logic [5:0]  name;
  logic [31:0] pc_out, imm;

  int          checks = 0;
  int          failures = 0;
  int          pulses = 0;
  int          drops = 0;
  logic [31:0] pc_ctr = '0;
  entry_t      cur;
  entry_t      q[$];
  bit          exp_ir = 1'b0;
  bit          exp_full = 1'b0;
  logic [80:0] exp_fields = '0;

  param_iqueue #(.DEPTH(DEPTH), .AF_MARGIN(AF), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .inst_rdy(inst_rdy),
    .inst(inst), .pc_in(pc_in), .iqueue_full(iqueue_full), .ins_rdy(ins_rdy),
    .bubble(bubble), .op1_rdy(op1_rdy), .op2_rdy(op2_rdy), .rs1(rs1), .rs2(rs2),
    .issue_rdy(issue_rdy), .rd(rd), .itype(itype), .name(name), .is_vec(is_vec),
    .is_imm(is_imm), .is_pc(is_pc), .pc_out(pc_out), .imm(imm)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Builds an instruction word from chosen fields; the expected decode is
  // whatever those fields mean, not a decode of the word.
  function automatic entry_t make_entry(input int kind, input logic [31:0] pc);
    entry_t      e;
    logic [31:0] r;
    logic [4:0]  d, s1, s2;
    r  = $urandom;
    d  = 5'($urandom_range(1, 31));
    s1 = 5'($urandom_range(0, 31));
    s2 = 5'($urandom_range(0, 31));
    e = '0;
    e.pc = pc; e.rd = d; e.rs1 = s1; e.rs2 = s2;
    case (kind)
      K_ADD, K_SUB: begin
        e.inst = {(kind == K_SUB) ? 7'b0100000 : 7'b0000000, s2, s1, 3'b000, d, 7'b0110011};
        e.use_rs1 = 1; e.use_rs2 = 1; e.typ = 2'd0; e.nm = (kind == K_SUB) ? 6'd2 : 6'd1;
      end
      K_ADDI: begin
        e.inst = {r[11:0], s1, 3'b000, d, 7'b0010011};
        e.use_rs1 = 1; e.isimm = 1; e.typ = 2'd0; e.nm = 6'd11;
        e.imm = {{20{r[11]}}, r[11:0]};
      end
      K_LUI, K_AUIPC: begin
        e.inst = {r[31:12], d, (kind == K_LUI) ? 7'b0110111 : 7'b0010111};
        e.isimm = 1; e.ispc = 1; e.typ = 2'd0; e.nm = (kind == K_LUI) ? 6'd20 : 6'd21;
        e.imm = {r[31:12], 12'b0};
      end
      K_LW: begin
        e.inst = {r[11:0], s1, 3'b010, d, 7'b0000011};
        e.use_rs1 = 1; e.isimm = 1; e.typ = 2'd1; e.nm = 6'd32;
        e.imm = {{20{r[11]}}, r[11:0]};
      end
      K_SW: begin
        e.inst = {r[11:5], s2, s1, 3'b010, r[4:0], 7'b0100011};
        e.use_rs1 = 1; e.use_rs2 = 1; e.typ = 2'd1; e.nm = 6'd37; e.rd = '0;
        e.imm = {{20{r[11]}}, r[11:0]};
      end
      K_BEQ: begin
        e.inst = {r[12], r[10:5], s2, s1, 3'b000, r[4:1], r[11], 7'b1100011};
        e.use_rs1 = 1; e.use_rs2 = 1; e.typ = 2'd2; e.nm = 6'd24; e.rd = '0;
        e.imm = {{19{r[12]}}, r[12:1], 1'b0};
      end
      K_JAL: begin
        e.inst = {r[20], r[10:1], r[11], r[19:12], d, 7'b1101111};
        e.isimm = 1; e.ispc = 1; e.typ = 2'd2; e.nm = 6'd22;
        e.imm = {{11{r[20]}}, r[20:1], 1'b0};
      end
      default: begin
        e.inst = {6'b000000, 1'b1, s2, s1, 3'b000, d, 7'b1010111};
        e.use_rs1 = 1; e.use_rs2 = 1; e.typ = 2'd3; e.nm = 6'd38; e.vec = 1;
      end
    endcase
    return e;
  endfunction

  task automatic new_inst(input int kind);
    cur   = make_entry(kind, pc_ctr);
    pc_ctr = pc_ctr + 32'd4;
    inst  = cur.inst;
    pc_in = cur.pc;
  endtask

  // One clock: predict from the model, take the edge, compare.
  task automatic step();
    bit     iss, enq;
    entry_t e;
    if (q.size() > 0) begin
      if (q[0].use_rs1) check("rs1", 128'(rs1), 128'(q[0].rs1));
      if (q[0].use_rs2) check("rs2", 128'(rs2), 128'(q[0].rs2));
    end
    if (rst) begin
      q.delete(); exp_ir = 0; exp_full = 0; exp_fields = '0;
    end else if (rdy) begin
      if (flush) begin
        q.delete(); exp_ir = 0; exp_full = 0;
      end else begin
        iss = ins_rdy && !bubble && (q.size() > 0)
              && (q[0].ispc || op1_rdy) && (q[0].isimm || op2_rdy);
        enq = 0;
        if (inst_rdy) begin
          if (q.size() < DEPTH) enq = 1;
          else begin
            drops++;
            $display("note: inst_rdy while queue holds %0d entries, word pc=%h dropped (protocol violation)",
                     q.size(), cur.pc);
          end
        end
        if (iss) begin
          e = q.pop_front();
          exp_fields = {e.rd, e.typ, e.nm, e.vec, e.isimm, e.ispc, e.pc, e.imm};
        end
        if (enq) q.push_back(cur);
        exp_ir   = iss;
        exp_full = (q.size() >= DEPTH - AF);
      end
    end
    @(posedge clk);
    #1;
    check("issue_rdy", 128'(issue_rdy), 128'(exp_ir));
    check("iqueue_full", 128'(iqueue_full), 128'(exp_full));
    check("fields", 128'({rd, itype, name, is_vec, is_imm, is_pc, pc_out, imm}), 128'(exp_fields));
    if (issue_rdy) begin
      pulses++;
      $display("issue pc=%h name=%0d type=%0d rd=%0d imm=%h", pc_out, name, itype, rd, imm);
    end
  endtask

  initial begin
    rst = 1; rdy = 1; flush = 0; inst_rdy = 0; inst = '0; pc_in = '0;
    ins_rdy = 0; bubble = 0; op1_rdy = 0; op2_rdy = 0;
    step(); step();
    check("reset_outputs", 128'({issue_rdy, iqueue_full, rd, itype, name, is_vec, is_imm, is_pc, pc_out, imm}), 128'(0));
    rst = 0;

    // Three ADDs back to back, all operands ready.
    ins_rdy = 1; op1_rdy = 1; op2_rdy = 1; pulses = 0; pc_ctr = '0;
    for (int i = 0; i < 3; i++) begin new_inst(K_ADD); inst_rdy = 1; step(); end
    inst_rdy = 0;
    repeat (4) step();
    check("three_pulses", 128'(pulses), 128'(3));

    // Fill to the almost-full threshold and beyond, then drain.
    rst = 1; step(); rst = 0; ins_rdy = 0; inst_rdy = 1;
    for (int i = 0; i < 16; i++) begin
      new_inst($urandom_range(0, 9));
      step();
      if (i == 12) check("full_after_13", 128'(iqueue_full), 128'(0));
      if (i == 13) check("full_after_14", 128'(iqueue_full), 128'(1));
    end
    new_inst(K_ADDI); step();
    ins_rdy = 1; new_inst(K_ADDI); step();
    inst_rdy = 0; pulses = 0;
    repeat (18) step();
    check("drain_count", 128'(pulses), 128'(15));

    // Steady stream across pointer wrap at constant occupancy.
    rst = 1; step(); rst = 0; ins_rdy = 0; inst_rdy = 1;
    for (int i = 0; i < 5; i++) begin new_inst($urandom_range(0, 9)); step(); end
    ins_rdy = 1; pulses = 0;
    for (int i = 0; i < 40; i++) begin new_inst($urandom_range(0, 9)); step(); end
    inst_rdy = 0;
    repeat (8) step();
    check("stream_count", 128'(pulses), 128'(45));

    // Operand readiness gating, and PC/imm forms ignoring it.
    rst = 1; step(); rst = 0; ins_rdy = 1; op1_rdy = 0; op2_rdy = 1;
    new_inst(K_ADD); inst_rdy = 1; step(); inst_rdy = 0; pulses = 0;
    repeat (3) step();
    check("add_waits_op1", 128'(pulses), 128'(0));
    op1_rdy = 1; step(); step();
    check("add_issued", 128'(pulses), 128'(1));
    op1_rdy = 0; op2_rdy = 0;
    new_inst(K_LUI); inst_rdy = 1; step(); inst_rdy = 0;
    step(); step();
    check("lui_issued", 128'(pulses), 128'(2));

    // Flush with a same-cycle enqueue, then a fresh entry.
    rst = 1; step(); rst = 0; ins_rdy = 0; inst_rdy = 1;
    for (int i = 0; i < 5; i++) begin new_inst($urandom_range(0, 9)); step(); end
    flush = 1; new_inst(K_ADDI); step();
    flush = 0; inst_rdy = 0; ins_rdy = 1; op1_rdy = 1; op2_rdy = 1; pulses = 0;
    repeat (3) step();
    check("flush_no_issue", 128'(pulses), 128'(0));
    pc_ctr = 32'h100; new_inst(K_ADD); inst_rdy = 1; step(); inst_rdy = 0;
    repeat (2) step();
    check("post_flush_issue", 128'(pulses), 128'(1));

    // Global enable low freezes everything, flush included.
    rst = 1; step(); rst = 0; ins_rdy = 0; inst_rdy = 1;
    for (int i = 0; i < 3; i++) begin new_inst($urandom_range(0, 9)); step(); end
    rdy = 0; flush = 1; ins_rdy = 1; new_inst(K_ADD); pulses = 0;
    repeat (3) step();
    check("frozen_no_issue", 128'(pulses), 128'(0));
    rdy = 1; flush = 0; inst_rdy = 0;
    repeat (5) step();
    check("resumed_issue", 128'(pulses), 128'(3));

    // Reset mid-stream discards queued entries.
    ins_rdy = 0; inst_rdy = 1;
    for (int i = 0; i < 4; i++) begin new_inst($urandom_range(0, 9)); step(); end
    inst_rdy = 0; ins_rdy = 1; rst = 1; step(); rst = 0; pulses = 0;
    repeat (4) step();
    check("reset_discards", 128'(pulses), 128'(0));

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      rdy      = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 39) == 0);
      inst_rdy = !iqueue_full && ($urandom_range(0, 2) != 0);
      ins_rdy  = ($urandom_range(0, 3) != 0);
      bubble   = ($urandom_range(0, 5) == 0);
      op1_rdy  = ($urandom_range(0, 3) != 0);
      op2_rdy  = ($urandom_range(0, 3) != 0);
      new_inst($urandom_range(0, 9));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
